// File: rtl/timer_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_ctrl_pkg
// Description : Shared state encoding and default widths for the interval timer.
// Revision    : 1.0 - initial release
// ============================================================================
package timer_ctrl_pkg;

    localparam int c_cnt_w_default  = 32;
    localparam int c_pcnt_w_default = 16;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_clear = 2'd1;
    localparam logic [1:0] c_st_run   = 2'd2;
    localparam logic [1:0] c_st_hold  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = c_st_idle,
        ST_CLEAR = c_st_clear,
        ST_RUN   = c_st_run,
        ST_HOLD  = c_st_hold
    } state_t;

endpackage
`default_nettype wire

// File: rtl/counter_32bits.sv
`default_nettype none
// ============================================================================
// Module      : counter_32bits
// Description : Up-counter with synchronous clear and count enable.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_32bits #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             count_en,
    output logic [WIDTH-1:0] Q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            Q <= '0;
        end else if (count_en) begin
            Q <= Q + WIDTH'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/interval_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : interval_timer_ctrl
// Description : One-shot / periodic interval timer with pause, resume and abort.
// Revision    : 1.0 - initial release
// ============================================================================
module interval_timer_ctrl
    import timer_ctrl_pkg::*;
#(
    parameter int CNT_W  = c_cnt_w_default,
    parameter int PCNT_W = c_pcnt_w_default
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              mode,
    input  logic [CNT_W-1:0]  limit,
    output logic [CNT_W-1:0]  count,
    output logic              busy,
    output logic              done,
    output logic [PCNT_W-1:0] periods
);

    state_t              r_state;
    logic [CNT_W-1:0]    r_limit;
    logic                r_mode;
    logic                r_busy;
    logic                r_done;
    logic [PCNT_W-1:0]   r_periods;

    logic [CNT_W-1:0]    w_count;
    logic                w_match;
    logic                w_count_en;
    logic                w_cnt_rst;

    assign w_match    = (w_count == r_limit);
    // A stop request freezes the counter on the very cycle it is seen.
    assign w_count_en = (r_state == ST_RUN) && !w_match && !stop;
    assign w_cnt_rst  = reset || (r_state == ST_CLEAR);

    counter_32bits #(
        .WIDTH (CNT_W)
    ) u_counter (
        .clk      (clk),
        .reset    (w_cnt_rst),
        .count_en (w_count_en),
        .Q        (w_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_limit   <= '0;
            r_mode    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_periods <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_limit   <= limit;
                        r_mode    <= mode;
                        r_periods <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (w_match) begin
                        r_done <= 1'b1;
                        if (r_periods != {PCNT_W{1'b1}}) begin
                            r_periods <= r_periods + PCNT_W'(1);
                        end
                        if (r_mode) begin
                            r_state <= ST_CLEAR;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end else if (stop) begin
                        r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (stop) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (start) begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign count   = w_count;
    assign busy    = r_busy;
    assign done    = r_done;
    assign periods = r_periods;

endmodule
`default_nettype wire

// File: tb/tb_interval_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_interval_timer_ctrl
// Description : Self-checking bench: vector table, corner sequences, random vs model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_interval_timer_ctrl;

    localparam int CNT_W  = 32;
    localparam int PCNT_W = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              mode = 1'b0;
    logic [CNT_W-1:0]  limit = '0;
    logic [CNT_W-1:0]  count;
    logic              busy;
    logic              done;
    logic [PCNT_W-1:0] periods;

    int checks = 0;
    int failures = 0;

    interval_timer_ctrl #(
        .CNT_W  (CNT_W),
        .PCNT_W (PCNT_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .stop    (stop),
        .mode    (mode),
        .limit   (limit),
        .count   (count),
        .busy    (busy),
        .done    (done),
        .periods (periods)
    );

    always #5 clk = ~clk;

    // Behavioural model: a timer is either inactive or active; an active timer
    // is zeroing its count, paused, or counting toward its latched limit.
    bit          m_active, m_zeroing, m_paused, m_mode, m_done;
    int unsigned m_count, m_limit, m_periods;

    task automatic model_step(input bit r, s, p, md, input int unsigned l);
        m_done = 1'b0;
        if (r) begin
            m_active = 0; m_zeroing = 0; m_paused = 0; m_mode = 0;
            m_count = 0; m_limit = 0; m_periods = 0;
        end else if (!m_active) begin
            if (s) begin
                m_active = 1; m_zeroing = 1; m_limit = l; m_mode = md; m_periods = 0;
            end
        end else if (m_zeroing) begin
            m_count = 0; m_zeroing = 0;
        end else if (m_paused) begin
            if (p) begin m_active = 0; m_paused = 0; end
            else if (s) m_paused = 0;
        end else if (m_count == m_limit) begin
            m_done = 1'b1;
            if (m_periods < (1 << PCNT_W) - 1) m_periods++;
            if (m_mode) m_zeroing = 1; else m_active = 0;
        end else if (p) begin
            m_paused = 1;
        end else begin
            m_count++;
        end
    endtask

    task automatic cyc(input bit r, s, p, md, input int unsigned l);
        reset = r; start = s; stop = p; mode = md; limit = l;
        @(posedge clk);
        model_step(r, s, p, md, l);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit          rst, st, sp, md;
        int unsigned lim;
        int unsigned e_cnt;
        bit          e_busy, e_done;
        int unsigned e_per;
    } vec_t;

    vec_t tbl[11];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n;
        bit found;

        // One-shot limit=2 with start+stop in IDLE, stop at terminal, busy-start ignored, limit=0
        tbl[0]  = '{1,0,0,0,0, 0,0,0,0};
        tbl[1]  = '{0,1,1,0,2, 0,1,0,0};
        tbl[2]  = '{0,0,0,1,9, 0,1,0,0};
        tbl[3]  = '{0,1,0,0,9, 1,1,0,0};
        tbl[4]  = '{0,0,0,0,0, 2,1,0,0};
        tbl[5]  = '{0,0,1,0,0, 2,0,1,1};
        tbl[6]  = '{0,0,0,0,0, 2,0,0,1};
        tbl[7]  = '{0,1,0,0,0, 2,1,0,0};
        tbl[8]  = '{0,0,0,0,0, 0,1,0,0};
        tbl[9]  = '{0,0,0,0,0, 0,0,1,1};
        tbl[10] = '{0,0,0,0,0, 0,0,0,1};
        for (int i = 0; i < 11; i++) begin
            cyc(tbl[i].rst, tbl[i].st, tbl[i].sp, tbl[i].md, tbl[i].lim);
            chk($sformatf("tbl%0d_count", i), count, tbl[i].e_cnt);
            chk($sformatf("tbl%0d_busy", i), busy, 32'(tbl[i].e_busy));
            chk($sformatf("tbl%0d_done", i), done, 32'(tbl[i].e_done));
            chk($sformatf("tbl%0d_periods", i), periods, tbl[i].e_per);
        end

        // Pause, hold, resume to completion
        cyc(1,0,0,0,0);
        cyc(0,1,0,0,10);
        repeat (5) cyc(0,0,0,0,0);
        chk("pause_pre_count", count, 4);
        cyc(0,0,1,0,0);
        chk("hold_count", count, 4);
        for (int i = 0; i < 3; i++) begin
            cyc(0,0,0,0,0);
            chk("hold_count_stable", count, 4);
            chk("hold_busy", busy, 1);
        end
        cyc(0,1,0,0,0);
        chk("resume_count", count, 4);
        n = 0; found = 0;
        for (int i = 1; i <= 20 && !found; i++) begin
            cyc(0,0,0,0,0);
            if (done) begin found = 1; n = i; end
        end
        chk("resume_done_latency", n, 7);
        chk("resume_done_count", count, 10);

        // Pause then abort
        cyc(0,1,0,0,10);
        repeat (5) cyc(0,0,0,0,0);
        cyc(0,0,1,0,0);
        chk("abort_hold_count", count, 4);
        cyc(0,0,1,0,0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_count", count, 4);
        chk("abort_periods", periods, 0);
        cyc(0,0,0,0,0);
        chk("abort_after_done", done, 0);

        // Reset mid-run, then a new limit applies
        cyc(0,1,0,0,20);
        repeat (8) cyc(0,0,0,0,0);
        chk("midrun_count", count, 7);
        cyc(1,1,1,0,0);
        chk("rst_count", count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_periods", periods, 0);
        cyc(0,1,0,0,2);
        n = 0; found = 0;
        for (int i = 1; i <= 20 && !found; i++) begin
            cyc(0,0,0,0,0);
            if (done) begin found = 1; n = i; end
        end
        chk("newlimit_latency", n, 4);
        chk("newlimit_count", count, 2);

        // Periodic limit=3: done every 5 cycles
        cyc(1,0,0,0,0);
        cyc(0,1,0,1,3);
        for (int k = 1; k <= 25; k++) begin
            cyc(0,0,0,0,0);
            chk($sformatf("periodic_done_k%0d", k), done, (k % 5 == 0) ? 1 : 0);
            chk("periodic_busy", busy, 1);
        end
        chk("periodic_periods", periods, 5);

        // Periodic limit=0: period of 2, periods saturate at 15
        cyc(1,0,0,0,0);
        cyc(0,1,0,1,0);
        for (int k = 1; k <= 40; k++) begin
            cyc(0,0,0,0,0);
            if (k == 20) chk("sat_periods_mid", periods, 10);
        end
        chk("sat_periods_end", periods, 15);

        // Randomised traffic against the model
        cyc(1,0,0,0,0);
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom % 100) == 0, ($urandom % 4) == 0, ($urandom % 8) == 0,
                1'($urandom), $urandom % 6);
            chk("rnd_count", count, m_count);
            chk("rnd_busy", busy, 32'(m_active));
            chk("rnd_done", done, 32'(m_done));
            chk("rnd_periods", periods, m_periods);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
